robot_cmd_controller: RTL and testbench
=======================================

// Module: robot_cmd_controller
// PURPOSE
//  Parses the UART RX byte stream into '#'-terminated ASCII command words and runs the robot mission FSM.
//  Supported words: START, STOP, PAUSE, RESUME.
//  Sits between uart_rx (rx_complete/data_in) and the motion/path logic (robot_enabled, paused, done).
// PARAMETERS
//  MAX_LEN   8      max characters per word held in the buffer (>=6)
//  TERM      8'h23  terminator byte ('#')
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  rx_complete   in   1  1-cycle strobe: data_in valid
//  data_in       in   8  received byte
//  done          in   1  1-cycle strobe from path logic: run finished
//  robot_enabled out  1  1 while state==RUN
//  paused        out  1  1 while state==PAUSE
//  run_state     out  2  IDLE=00 RUN=01 PAUSE=10 FINISH=11
//  cmd_error     out  1  1-cycle pulse on a rejected word or command
//  runs_done     out  8  completed-run counter, saturates at 255
//  tx_busy       in   1  [ACK_EN] uart_tx busy
//  tx_start      out  1  [ACK_EN] 1-cycle send strobe
//  tx_data       out  8  [ACK_EN] ack byte
// BEHAVIOUR
//  Reset: state=IDLE, len=0, overflow=0; all outputs 0 (tx_data=0).
//  All outputs are registered.
//  Word buffer:
//   - rx_complete with a non-TERM byte and len<MAX_LEN: buf[len]<=byte, len++.
//   - Non-TERM byte with len==MAX_LEN: set overflow; the byte is discarded.
//   - rx_complete with TERM, len==0: ignored. No error, no ack.
//   - rx_complete with TERM, len>0: decode buf[0..len-1].
//     Exact, case-sensitive, length-exact match against the four keywords.
//     Overflow or no match => unknown word.
//     len and overflow then clear in the same cycle.
//  Latency: FSM and outputs update on the clock edge after the TERM strobe cycle (1 cycle).
//  FSM transitions; any other command/state pair => cmd_error, state unchanged:
//   IDLE:   START->RUN
//   RUN:    PAUSE->PAUSE; STOP->IDLE; done->FINISH, runs_done++ (saturating)
//   PAUSE:  RESUME->RUN; STOP->IDLE
//   FINISH: START->RUN; STOP->IDLE
//  done outside RUN: ignored.
//  Unknown word: cmd_error pulse, state unchanged.
//  done and a decoded command in the same cycle in RUN: done wins (FINISH); the command is rejected with cmd_error.
//  Reset mid-word: partial word is lost; following bytes start a new word.
// CONFIGURATION
//  ROBOT_CMD_ACK_EN defined:
//   - Each decoded non-empty word queues one ack: 'K' (8'h4B) if accepted, 'E' (8'h45) if cmd_error.
//   - One-deep pending slot; a newer ack overwrites an unsent one.
//   - tx_start pulses for 1 cycle with tx_data valid in the first cycle tx_busy==0 while the slot is pending; the slot clears then.
//  ROBOT_CMD_ACK_EN undefined: tx_* ports and all ack logic are absent.
// STRUCTURE
//  robot_cmd_pkg: state encodings, keyword byte constants, ACK_OK/ACK_ERR bytes, command enum (CMD_NONE/START/STOP/PAUSE/RESUME/UNKNOWN).
//  Sub-module cmd_word_buffer: accumulates bytes, tracks overflow, emits a 1-cycle cmd_valid with the cmd enum.
//  The top level holds the FSM, the counter and the ack logic.
// TESTING
//  1. "START#" after reset -> robot_enabled=1, run_state=01 one cycle after the '#' strobe; cmd_error stays 0.
//  2. In RUN, "PAUSE#" -> paused=1, robot_enabled=0; then "RESUME#" -> run_state=01 and paused=0.
//  3. done in RUN -> run_state=11, robot_enabled=0, runs_done=1; done in IDLE -> no change.
//     256 runs -> runs_done holds 255.
//  4. Rejected words "STARTX#", "start#", "ABCDEFGHI#" (overflow) -> cmd_error 1-cycle pulse, state unchanged.
//     "#" alone -> no pulse. "RESUME#" in IDLE -> cmd_error.
//  5. In RUN, done coincident with the '#' of "STOP#" -> run_state=11, cmd_error=1.
//     "ST", then reset, then "OP#" -> cmd_error, state IDLE.
//  6. [ACK_EN] "START#" with tx_busy=1 for 10 cycles -> no tx_start until tx_busy falls, then one tx_start with tx_data=8'h4B.
//     "XX#" then "STOP#" while busy -> only the 'E'/'K' ack pending at busy release is sent.

Source files
------------

// File: rtl/robot_cmd_pkg.sv
// Shared encodings for the robot command controller: FSM states, command codes,
// keyword byte strings and ack bytes, plus the keyword decoder.
package robot_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_FINISH = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_START   = 3'd1,
    CMD_STOP    = 3'd2,
    CMD_PAUSE   = 3'd3,
    CMD_RESUME  = 3'd4,
    CMD_UNKNOWN = 3'd5
  } cmd_e;

  localparam int          DEF_MAX_LEN = 8;
  localparam logic [7:0]  DEF_TERM    = 8'h23;
  localparam logic [7:0]  ACK_OK      = 8'h4B;
  localparam logic [7:0]  ACK_ERR     = 8'h45;

  // Keywords are right-aligned: the first character sits in the highest used byte.
  localparam logic [47:0] KW_START  = 48'("START");
  localparam logic [47:0] KW_STOP   = 48'("STOP");
  localparam logic [47:0] KW_PAUSE  = 48'("PAUSE");
  localparam logic [47:0] KW_RESUME = 48'("RESUME");

  function automatic logic word_eq(input logic [5:0][7:0] w, input int len,
                                   input logic [47:0] kw, input int kw_len);
    logic eq;
    int   sh;
    eq = (len == kw_len);
    for (int i = 0; i < 6; i++) begin
      sh = (i < kw_len) ? 8 * (kw_len - 1 - i) : 0;
      if (i < kw_len && w[i] != kw[sh +: 8]) eq = 1'b0;
    end
    return eq;
  endfunction

  function automatic cmd_e decode_word(input logic [5:0][7:0] w, input int len);
    cmd_e c;
    c = CMD_UNKNOWN;
    if (word_eq(w, len, KW_START, 5))  c = CMD_START;
    if (word_eq(w, len, KW_STOP, 4))   c = CMD_STOP;
    if (word_eq(w, len, KW_PAUSE, 5))  c = CMD_PAUSE;
    if (word_eq(w, len, KW_RESUME, 6)) c = CMD_RESUME;
    return c;
  endfunction

endpackage

// File: rtl/cmd_word_buffer.sv
// Collects received bytes into a word and decodes it when the terminator
// arrives; cmd_valid/cmd are presented combinationally in the terminator cycle.
module cmd_word_buffer
  import robot_cmd_pkg::*;
#(
  parameter int         MAX_LEN = DEF_MAX_LEN,
  parameter logic [7:0] TERM    = DEF_TERM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_complete,
  input  logic [7:0] data_in,
  output logic       cmd_valid,
  output cmd_e       cmd
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  logic [MAX_LEN-1:0][7:0] buf_q, buf_d;
  logic [LW-1:0]           len_q, len_d;
  logic                    ovf_q, ovf_d;

  always_comb begin
    buf_d     = buf_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    cmd_valid = 1'b0;
    cmd       = CMD_NONE;
    if (rx_complete) begin
      if (data_in == TERM) begin
        if (len_q != '0) begin
          cmd_valid = 1'b1;
          cmd       = ovf_q ? CMD_UNKNOWN : decode_word(buf_q[5:0], int'(len_q));
          len_d     = '0;
          ovf_d     = 1'b0;
        end
      end else if (len_q < LEN_MAX) begin
        for (int i = 0; i < MAX_LEN; i++)
          if (LW'(i) == len_q) buf_d[i] = data_in;
        len_d = len_q + LW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/robot_cmd_controller.sv
// Robot mission FSM driven by '#'-terminated UART command words.
// Define ROBOT_CMD_ACK_EN to add the 'K'/'E' acknowledge path on tx_*.
module robot_cmd_controller
  import robot_cmd_pkg::*;
#(
  parameter int         MAX_LEN = DEF_MAX_LEN,
  parameter logic [7:0] TERM    = DEF_TERM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_complete,
  input  logic [7:0] data_in,
  input  logic       done,
  output logic       robot_enabled,
  output logic       paused,
  output logic [1:0] run_state,
  output logic       cmd_error,
  output logic [7:0] runs_done
`ifdef ROBOT_CMD_ACK_EN
  ,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data
`endif
);

  logic   cmd_valid;
  cmd_e   cmd;

  state_e     state_q, state_d;
  logic [7:0] runs_q, runs_d;
  logic       err_q, err_d;
  logic       en_q, en_d;
  logic       paused_q, paused_d;

  cmd_word_buffer #(.MAX_LEN(MAX_LEN), .TERM(TERM)) u_buf (
    .clk         (clk),
    .reset       (reset),
    .rx_complete (rx_complete),
    .data_in     (data_in),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd)
  );

  // A run completing takes priority over any command decoded in the same cycle.
  always_comb begin
    state_d = state_q;
    runs_d  = runs_q;
    err_d   = 1'b0;
    if (done && state_q == ST_RUN) begin
      state_d = ST_FINISH;
      if (runs_q != 8'hFF) runs_d = runs_q + 8'd1;
      err_d = cmd_valid;
    end else if (cmd_valid) begin
      err_d = 1'b1;
      unique case (state_q)
        ST_IDLE: if (cmd == CMD_START) begin state_d = ST_RUN; err_d = 1'b0; end
        ST_RUN: begin
          if (cmd == CMD_PAUSE) begin state_d = ST_PAUSE; err_d = 1'b0; end
          if (cmd == CMD_STOP)  begin state_d = ST_IDLE;  err_d = 1'b0; end
        end
        ST_PAUSE: begin
          if (cmd == CMD_RESUME) begin state_d = ST_RUN;  err_d = 1'b0; end
          if (cmd == CMD_STOP)   begin state_d = ST_IDLE; err_d = 1'b0; end
        end
        ST_FINISH: begin
          if (cmd == CMD_START) begin state_d = ST_RUN;  err_d = 1'b0; end
          if (cmd == CMD_STOP)  begin state_d = ST_IDLE; err_d = 1'b0; end
        end
        default: ;
      endcase
    end
    en_d     = (state_d == ST_RUN);
    paused_d = (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      runs_q   <= '0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      runs_q   <= runs_d;
      err_q    <= err_d;
      en_q     <= en_d;
      paused_q <= paused_d;
    end
  end

  assign robot_enabled = en_q;
  assign paused        = paused_q;
  assign run_state     = state_q;
  assign cmd_error     = err_q;
  assign runs_done     = runs_q;

`ifdef ROBOT_CMD_ACK_EN
  logic       pend_q, pend_d;
  logic [7:0] ack_q, ack_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;

  // Single pending slot: a fresh ack in the same cycle as a send becomes the next one.
  always_comb begin
    pend_d     = pend_q;
    ack_d      = ack_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (pend_q && !tx_busy) begin
      tx_start_d = 1'b1;
      tx_data_d  = ack_q;
      pend_d     = 1'b0;
    end
    if (cmd_valid) begin
      pend_d = 1'b1;
      ack_d  = err_d ? ACK_ERR : ACK_OK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
`endif

endmodule

// File: tb/tb_robot_cmd_controller.sv
// Directed self-checking bench for robot_cmd_controller; the ack scenario is
// exercised only when ROBOT_CMD_ACK_EN is defined.
module tb_robot_cmd_controller;

  logic       clk;
  logic       reset;
  logic       rx_complete;
  logic [7:0] data_in;
  logic       done;
  logic       robot_enabled;
  logic       paused;
  logic [1:0] run_state;
  logic       cmd_error;
  logic [7:0] runs_done;
`ifdef ROBOT_CMD_ACK_EN
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int err_seen = 0;
  int tx_count = 0;
  logic [7:0] last_tx = 8'h00;

  robot_cmd_controller dut (
    .clk           (clk),
    .reset         (reset),
    .rx_complete   (rx_complete),
    .data_in       (data_in),
    .done          (done),
    .robot_enabled (robot_enabled),
    .paused        (paused),
    .run_state     (run_state),
    .cmd_error     (cmd_error),
    .runs_done     (runs_done)
`ifdef ROBOT_CMD_ACK_EN
    ,
    .tx_busy       (tx_busy),
    .tx_start      (tx_start),
    .tx_data       (tx_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse monitors sample mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmd_error) err_seen++;
`ifdef ROBOT_CMD_ACK_EN
    if (tx_start) begin
      tx_count++;
      last_tx = tx_data;
    end
`endif
  end

  // Called at a negedge; returns at the next negedge with outputs reflecting the byte.
  task automatic send_byte(input logic [7:0] b);
    rx_complete = 1'b1;
    data_in     = b;
    @(negedge clk);
    rx_complete = 1'b0;
    data_in     = 8'h00;
  endtask

  task automatic send_word(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(8'h23);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++; if (robot_enabled !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_en: got %b want 0", robot_enabled); end
    vec_cnt++; if (paused !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_paused: got %b want 0", paused); end
    vec_cnt++; if (run_state !== 2'b00) begin miss_cnt++; $display("[TB] FAIL reset_state: got %b want 00", run_state); end
    vec_cnt++; if (cmd_error !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_err: got %b want 0", cmd_error); end
    vec_cnt++; if (runs_done !== 8'd0) begin miss_cnt++; $display("[TB] FAIL reset_runs: got %0d want 0", runs_done); end
`ifdef ROBOT_CMD_ACK_EN
    vec_cnt++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin miss_cnt++; $display("[TB] FAIL reset_tx: got %b/%h want 0/00", tx_start, tx_data); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start();
    int e0;
    e0 = err_seen;
    send_word("STAR");
    vec_cnt++; if (run_state !== 2'b00) begin miss_cnt++; $display("[TB] FAIL start_partial: got %b want 00", run_state); end
    send_word("START");
    vec_cnt++; if (run_state !== 2'b01) begin miss_cnt++; $display("[TB] FAIL start_state: got %b want 01", run_state); end
    vec_cnt++; if (robot_enabled !== 1'b1) begin miss_cnt++; $display("[TB] FAIL start_en: got %b want 1", robot_enabled); end
    @(negedge clk);
    vec_cnt++; if (err_seen - e0 !== 1) begin miss_cnt++; $display("[TB] FAIL start_err_count: got %0d want 1", err_seen - e0); end
  endtask

  task automatic test_pause_resume();
    send_word("PAUSE");
    vec_cnt++; if (paused !== 1'b1 || robot_enabled !== 1'b0 || run_state !== 2'b10) begin
      miss_cnt++; $display("[TB] FAIL pause: got p=%b en=%b st=%b want 1/0/10", paused, robot_enabled, run_state); end
    send_word("RESUME");
    vec_cnt++; if (paused !== 1'b0 || robot_enabled !== 1'b1 || run_state !== 2'b01) begin
      miss_cnt++; $display("[TB] FAIL resume: got p=%b en=%b st=%b want 0/1/01", paused, robot_enabled, run_state); end
  endtask

  task automatic test_done();
    pulse_done();
    vec_cnt++; if (run_state !== 2'b11 || robot_enabled !== 1'b0) begin
      miss_cnt++; $display("[TB] FAIL done_state: got st=%b en=%b want 11/0", run_state, robot_enabled); end
    vec_cnt++; if (runs_done !== 8'd1) begin miss_cnt++; $display("[TB] FAIL done_runs: got %0d want 1", runs_done); end
    send_word("STOP");
    vec_cnt++; if (run_state !== 2'b00) begin miss_cnt++; $display("[TB] FAIL finish_stop: got %b want 00", run_state); end
    pulse_done();
    vec_cnt++; if (run_state !== 2'b00 || runs_done !== 8'd1) begin
      miss_cnt++; $display("[TB] FAIL done_idle: got st=%b runs=%0d want 00/1", run_state, runs_done); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int r = 1; r <= 256; r++) begin
      send_word("START");
      pulse_done();
      if (r == 255) begin
        vec_cnt++; if (runs_done !== 8'd255) begin miss_cnt++; $display("[TB] FAIL runs_255: got %0d want 255", runs_done); end
      end
    end
    vec_cnt++; if (runs_done !== 8'd255 || run_state !== 2'b11) begin
      miss_cnt++; $display("[TB] FAIL runs_sat: got runs=%0d st=%b want 255/11", runs_done, run_state); end
  endtask

  task automatic test_reject();
    int e0;
    send_word("START");
    send_word("STARTX");
    vec_cnt++; if (cmd_error !== 1'b1 || run_state !== 2'b01) begin
      miss_cnt++; $display("[TB] FAIL rej_long: got err=%b st=%b want 1/01", cmd_error, run_state); end
    @(negedge clk);
    vec_cnt++; if (cmd_error !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rej_pulse_width: got %b want 0", cmd_error); end
    send_word("start");
    vec_cnt++; if (cmd_error !== 1'b1 || run_state !== 2'b01) begin
      miss_cnt++; $display("[TB] FAIL rej_case: got err=%b st=%b want 1/01", cmd_error, run_state); end
    send_word("ABCDEFGHI");
    vec_cnt++; if (cmd_error !== 1'b1 || run_state !== 2'b01) begin
      miss_cnt++; $display("[TB] FAIL rej_overflow: got err=%b st=%b want 1/01", cmd_error, run_state); end
    @(negedge clk);
    e0 = err_seen;
    send_byte(8'h23);
    repeat (2) @(negedge clk);
    vec_cnt++; if (err_seen !== e0 || run_state !== 2'b01) begin
      miss_cnt++; $display("[TB] FAIL empty_word: got pulses=%0d st=%b want 0/01", err_seen - e0, run_state); end
    send_word("STOP");
    vec_cnt++; if (cmd_error !== 1'b0 || run_state !== 2'b00) begin
      miss_cnt++; $display("[TB] FAIL stop_after_ovf: got err=%b st=%b want 0/00", cmd_error, run_state); end
    send_word("RESUME");
    vec_cnt++; if (cmd_error !== 1'b1 || run_state !== 2'b00) begin
      miss_cnt++; $display("[TB] FAIL resume_idle: got err=%b st=%b want 1/00", cmd_error, run_state); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    send_word("START");
    send_byte("S"); send_byte("T"); send_byte("O"); send_byte("P");
    rx_complete = 1'b1;
    data_in     = 8'h23;
    done        = 1'b1;
    @(negedge clk);
    rx_complete = 1'b0;
    done        = 1'b0;
    vec_cnt++; if (run_state !== 2'b11 || cmd_error !== 1'b1) begin
      miss_cnt++; $display("[TB] FAIL done_vs_stop: got st=%b err=%b want 11/1", run_state, cmd_error); end
    vec_cnt++; if (runs_done !== 8'd255) begin miss_cnt++; $display("[TB] FAIL done_vs_stop_runs: got %0d want 255", runs_done); end
    @(negedge clk);
    send_byte("S"); send_byte("T");
    do_reset();
    send_word("OP");
    vec_cnt++; if (cmd_error !== 1'b1 || run_state !== 2'b00) begin
      miss_cnt++; $display("[TB] FAIL reset_mid_word: got err=%b st=%b want 1/00", cmd_error, run_state); end
    @(negedge clk);
  endtask

`ifdef ROBOT_CMD_ACK_EN
  task automatic test_ack();
    int c0;
    do_reset();
    c0 = tx_count;
    tx_busy = 1'b1;
    send_word("START");
    repeat (10) @(negedge clk);
    vec_cnt++; if (tx_count !== c0) begin miss_cnt++; $display("[TB] FAIL ack_held: got %0d sends want 0", tx_count - c0); end
    tx_busy = 1'b0;
    repeat (4) @(negedge clk);
    vec_cnt++; if (tx_count - c0 !== 1 || last_tx !== 8'h4B) begin
      miss_cnt++; $display("[TB] FAIL ack_ok: got n=%0d data=%h want 1/4b", tx_count - c0, last_tx); end
    c0 = tx_count;
    tx_busy = 1'b1;
    send_word("XX");
    send_word("STOP");
    repeat (3) @(negedge clk);
    tx_busy = 1'b0;
    repeat (4) @(negedge clk);
    vec_cnt++; if (tx_count - c0 !== 1 || last_tx !== 8'h4B) begin
      miss_cnt++; $display("[TB] FAIL ack_overwrite_k: got n=%0d data=%h want 1/4b", tx_count - c0, last_tx); end
    c0 = tx_count;
    tx_busy = 1'b1;
    send_word("START");
    send_word("XX");
    repeat (3) @(negedge clk);
    tx_busy = 1'b0;
    repeat (4) @(negedge clk);
    vec_cnt++; if (tx_count - c0 !== 1 || last_tx !== 8'h45) begin
      miss_cnt++; $display("[TB] FAIL ack_overwrite_e: got n=%0d data=%h want 1/45", tx_count - c0, last_tx); end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    rx_complete = 1'b0;
    data_in     = 8'h00;
    done        = 1'b0;
`ifdef ROBOT_CMD_ACK_EN
    tx_busy     = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_start();
    test_pause_resume();
    test_done();
    test_saturate();
    test_reject();
    test_back_to_back();
`ifdef ROBOT_CMD_ACK_EN
    test_ack();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
